// File: rtl/rob_wide.sv
// Multi-commit reorder buffer: in-order allocate, NUM_CDB writebacks, up to
// COMMIT_W in-order retirements, head-store handshake and precise branch rollback.

module rob_wide_cdb_lane #(
  parameter int IXW = 3
) (
  input  logic           valid_in,
  input  logic [IXW-1:0] ix_in,
  input  logic [IXW-1:0] head_ix_in,
  input  logic [IXW:0]   count_in,
  input  logic           is_branch_in,
  input  logic           pred_in,
  input  logic           actual_in,
  output logic           wb_out,
  output logic           misp_out,
  output logic [IXW-1:0] age_out
);
  assign age_out  = ix_in - head_ix_in;
  assign wb_out   = valid_in && ({1'b0, age_out} < count_in);
  assign misp_out = wb_out && is_branch_in && (actual_in != pred_in);
endmodule

module rob_wide #(
  parameter int ROB_SIZE = 8,
  parameter int COMMIT_W = 2,
  parameter int NUM_CDB  = 2,
  parameter int DATA_W   = 32,
  parameter logic [3:0] ITYPE_BRANCH = 4'd1,
  parameter logic [3:0] ITYPE_STORE  = 4'd2,
  localparam int IXW = $clog2(ROB_SIZE)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       alloc_valid_in,
  input  logic [3:0]                 alloc_itype_in,
  input  logic [DATA_W-1:0]          alloc_value_in,
  input  logic [31:0]                alloc_dest_in,
  output logic                       alloc_ready_out,
  output logic [IXW-1:0]             alloc_ix_out,
  input  logic [NUM_CDB-1:0]         cdb_valid_in,
  input  logic [NUM_CDB*IXW-1:0]     cdb_ix_in,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_value_in,
  input  logic [NUM_CDB*32-1:0]      cdb_addr_in,
  output logic [COMMIT_W-1:0]        commit_valid_out,
  output logic [COMMIT_W*IXW-1:0]    commit_ix_out,
  output logic [COMMIT_W*4-1:0]      commit_itype_out,
  output logic [COMMIT_W*DATA_W-1:0] commit_value_out,
  output logic [COMMIT_W*32-1:0]     commit_dest_out,
  output logic                       store_valid_out,
  input  logic                       store_read_in,
  output logic                       flush_out,
  output logic [31:0]                flush_pc_out,
  output logic [IXW:0]               count_out
);
  logic [IXW:0] head_q, head_d, tail_q, tail_d, count, n_commit;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [ROB_SIZE-1:0][3:0]        itype_q, itype_d;
  logic [ROB_SIZE-1:0][DATA_W-1:0] value_q, value_d;
  logic [ROB_SIZE-1:0][31:0]       dest_q, dest_d;
  logic flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;

  logic [NUM_CDB-1:0][IXW-1:0]    cdb_ix;
  logic [NUM_CDB-1:0][DATA_W-1:0] cdb_val;
  logic [NUM_CDB-1:0][31:0]       cdb_addr;
  logic [NUM_CDB-1:0]             wb, misp;
  logic [NUM_CDB-1:0][IXW-1:0]    age;

  logic [IXW-1:0] head_ix, tail_ix, slot_ix, sel_age;
  logic alloc_fire, store_fire, run, ok, lv, any_misp;
  logic [31:0] sel_dest;

  assign cdb_ix   = cdb_ix_in;
  assign cdb_val  = cdb_value_in;
  assign cdb_addr = cdb_addr_in;
  assign head_ix  = head_q[IXW-1:0];
  assign tail_ix  = tail_q[IXW-1:0];
  assign count    = tail_q - head_q;

  // count only reaches its MSB when all ROB_SIZE entries are occupied
  assign alloc_ready_out = ~count[IXW];
  assign alloc_ix_out    = tail_ix;
  assign count_out       = count;
  assign alloc_fire      = alloc_valid_in && alloc_ready_out;
  assign store_valid_out = (count != '0) && ready_q[head_ix] && (itype_q[head_ix] == ITYPE_STORE);
  assign store_fire      = store_valid_out && store_read_in;
  assign flush_out       = flush_q;
  assign flush_pc_out    = flush_pc_q;

  for (genvar p = 0; p < NUM_CDB; p++) begin : g_lane
    rob_wide_cdb_lane #(.IXW(IXW)) u_lane (
      .valid_in    (cdb_valid_in[p]),
      .ix_in       (cdb_ix[p]),
      .head_ix_in  (head_ix),
      .count_in    (count),
      .is_branch_in(itype_q[cdb_ix[p]] == ITYPE_BRANCH),
      .pred_in     (value_q[cdb_ix[p]][0]),
      .actual_in   (cdb_val[p][0]),
      .wb_out      (wb[p]),
      .misp_out    (misp[p]),
      .age_out     (age[p])
    );
  end

  // Retirement scan: contiguous ready non-store entries from the head.
  always_comb begin
    n_commit         = '0;
    run              = 1'b1;
    slot_ix          = '0;
    ok               = 1'b0;
    lv               = 1'b0;
    commit_valid_out = '0;
    commit_ix_out    = '0;
    commit_itype_out = '0;
    commit_value_out = '0;
    commit_dest_out  = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_ix = head_ix + IXW'(k);
      lv      = (IXW+1)'(k) < count;
      ok      = run && lv && ready_q[slot_ix] && (itype_q[slot_ix] != ITYPE_STORE);
      run     = ok;
      commit_valid_out[k] = ok;
      n_commit = n_commit + (IXW+1)'(ok);
      if (lv) begin
        commit_ix_out[k*IXW +: IXW]       = slot_ix;
        commit_itype_out[k*4 +: 4]        = itype_q[slot_ix];
        commit_value_out[k*DATA_W +: DATA_W] = value_q[slot_ix];
        commit_dest_out[k*32 +: 32]       = dest_q[slot_ix];
      end
    end
  end

  // Oldest mispredict wins; strict compare keeps the lower port on ties.
  always_comb begin
    any_misp = 1'b0;
    sel_age  = '0;
    sel_dest = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (misp[p] && (!any_misp || age[p] < sel_age)) begin
        any_misp = 1'b1;
        sel_age  = age[p];
        sel_dest = dest_q[cdb_ix[p]];
      end
    end
  end

  always_comb begin
    itype_d = itype_q;
    value_d = value_q;
    dest_d  = dest_q;
    ready_d = ready_q;
    if (alloc_fire) begin
      itype_d[tail_ix] = alloc_itype_in;
      value_d[tail_ix] = alloc_value_in;
      dest_d[tail_ix]  = alloc_dest_in;
      ready_d[tail_ix] = 1'b0;
    end
    // descending so port 0 is applied last and wins a collision
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (wb[p]) begin
        ready_d[cdb_ix[p]] = 1'b1;
        if (itype_q[cdb_ix[p]] != ITYPE_BRANCH) value_d[cdb_ix[p]] = cdb_val[p];
        if (itype_q[cdb_ix[p]] == ITYPE_STORE)  dest_d[cdb_ix[p]]  = dest_q[cdb_ix[p]] + cdb_addr[p];
      end
    end
  end

  always_comb begin
    head_d     = head_q + n_commit + (IXW+1)'(store_fire);
    tail_d     = alloc_fire ? tail_q + (IXW+1)'(1) : tail_q;
    flush_d    = any_misp;
    flush_pc_d = any_misp ? sel_dest : flush_pc_q;
    if (any_misp) tail_d = head_q + (IXW+1)'(sel_age) + (IXW+1)'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      ready_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      ready_q    <= ready_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Payload is never reset; liveness gates everything visible.
  always_ff @(posedge clk_in) begin
    itype_q <= itype_d;
    value_q <= value_d;
    dest_q  <= dest_d;
  end
endmodule

// File: doc/rob_wide.md
# rob_wide

Parametrised reorder buffer for the superscalar core; successor to the single-commit ROB. It sits between issue/decode, the CDB and the register file/store unit. It allocates one entry per cycle in program order and accepts up to NUM_CDB writebacks per cycle. It retires up to COMMIT_W ready non-store entries per cycle, and on a branch mispredict it rolls the tail back precisely to just past the oldest mispredicted branch.

## Interface
- ROB_SIZE, 8: entry count; power of two, at least 2. IXW = $clog2(ROB_SIZE).
- COMMIT_W, 2: maximum retirements per cycle, 1..ROB_SIZE.
- NUM_CDB, 2: writeback ports.
- DATA_W, 32: value width.
- clk_in  in  1  clock; single clock domain.
- rst_in  in  1  reset, asynchronous, active-high.
- alloc_valid_in  in  1  issue requests an entry.
- alloc_itype_in  in  4  instruction type, codebase iType encoding (BRANCH, STORE, ...).
- alloc_value_in  in  DATA_W  initial value; for BRANCH, bit 0 is the predicted direction.
- alloc_dest_in  in  32  meaning depends on type: register index; store base address for STORE; recovery PC for BRANCH.
- alloc_ready_out  out  1  entry available: count_out < ROB_SIZE.
- alloc_ix_out  out  IXW  index that will be given to the next allocation (tail[IXW-1:0]).
- cdb_valid_in  in  NUM_CDB  per-port writeback valid.
- cdb_ix_in  in  NUM_CDB*IXW  per-port entry index, packed, port p at [p*IXW +: IXW].
- cdb_value_in  in  NUM_CDB*DATA_W  per-port result; for BRANCH, bit 0 is the actual direction.
- cdb_addr_in  in  NUM_CDB*32  per-port store address offset.
- commit_valid_out  out  COMMIT_W  slot k retires the (head+k) entry this cycle.
- commit_ix_out / commit_itype_out / commit_value_out / commit_dest_out  out  COMMIT_W*{IXW,4,DATA_W,32}  packed per-slot contents.
- store_valid_out  out  1  head entry is a ready STORE.
- store_read_in  in  1  store unit consumed the head store.
- flush_out  out  1  registered one-cycle mispredict pulse.
- flush_pc_out  out  32  recovery PC; valid while flush_out is high.
- count_out  out  IXW+1  occupied entries.

## Operation
- Head and tail are IXW+1-bit pointers, so the extra bit marks wrap. count = tail - head. An entry is live when its age (ix - head) mod ROB_SIZE < count.
- Allocation (alloc_valid_in && alloc_ready_out):
  - Write itype, value and dest at tail.
  - Clear the entry's ready bit.
  - tail += 1.
- CDB port p, valid with a live index:
  - Non-BRANCH: value <= cdb_value.
  - STORE: additionally dest <= dest + cdb_addr, modulo 2^32.
  - All types: ready <= 1.
  - A writeback to a non-live index is ignored.
  - Two ports naming the same index is illegal; the lower port wins.
- Mispredict: a BRANCH writeback where cdb_value[0] != stored value[0].
  - If several ports mispredict, the one with the smallest age is selected.
  - At the edge, tail <= head + age + 1, discarding every younger entry, including any allocation in the same cycle.
  - flush_out <= 1 and flush_pc_out <= the branch's dest.
  - The branch itself stays live, becomes ready and later commits normally.
- Commit is combinational from the head.
  - Slot k is valid iff entries head..head+k are all live, ready and non-STORE.
  - Scanning stops at the first non-ready entry or the first STORE.
  - At the edge, head += number of valid slots.
- Store at head:
  - Conditions: head entry is live, ready and STORE.
  - store_valid_out = 1 and all commit_valid_out are 0.
  - head += 1 at the edge where store_read_in = 1.
  - store_read_in while store_valid_out = 0 is ignored.
- Simultaneous events:
  - Allocation, writebacks, commit and rollback all resolve in one edge.
  - Rollback overrides the tail increment.
  - The head advance still applies. The branch is at or behind the new tail, so count stays ≥ 0.
- Full/empty:
  - alloc_ready_out uses the current count, so entries freed by commit this cycle are not reusable until the next cycle.
  - When empty, all commit and store outputs are 0.
- Wrap: indices wrap modulo ROB_SIZE. Full vs empty is distinguished by the wrap bit.

## Timing
- Reset (async assert): head = tail = 0, all ready bits = 0, flush_out = 0, flush_pc_out = 0. Consequently alloc_ready_out = 1, alloc_ix_out = 0, count_out = 0, commit_valid_out = 0, store_valid_out = 0.
- Reset asserted mid-operation discards all entries immediately and cancels any pending flush pulse.
- Entry contents, including itype, are not cleared by reset; outputs are gated by liveness.
- alloc_ix_out, alloc_ready_out, commit_* and store_valid_out are combinational from state.
- Latency:
  - An entry written back in cycle N can commit in cycle N+1 at the earliest.
  - An entry allocated in cycle N can accept a CDB write from cycle N+1.
- flush_out is high exactly in cycle N+1 after a mispredict writeback in cycle N. count_out already reflects the rollback in that cycle.
- A flush coinciding with the next mispredict restarts the pulse with the new PC.

## Test plan
- Reset, then allocate 8 OP entries to indices 0..7 → alloc_ready_out = 0, count_out = 8; a 9th alloc_valid_in is ignored.
- Write back indices 1, 0 and 2 in one cycle (two ports, then one) → next cycle commit_valid_out = 2'b11 for ix 0,1; the following cycle ix 2 commits alone; head = 3.
- Wrap: fill, commit 6, allocate 6 more → alloc_ix_out sequence 0..5 reused; commit order stays program order across the wrap.
- STORE at ix 0 with base 0x100 and cdb_addr 0x20 → store_valid_out = 1, dest_out 0x120, commit_valid_out = 0 until store_read_in; head advances exactly one.
- BRANCH at ix 2 predicted 1 with dest 0x400; entries 3..6 live; CDB resolves it to 0 → next cycle flush_out = 1, flush_pc_out = 0x400, count_out = 3, alloc_ix_out = 3; a same-cycle allocation is squashed.
- Two ports mispredict ix 5 and ix 3 with head = 2 → rollback to tail index 4; rst_in asserted during the flush cycle → flush_out = 0, count_out = 0 immediately.
